// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word-fall-through FIFO with registered head, count and sticky error flags.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        resetb,
  input  logic                        serial_rx,
  input  logic                        rd_en,
  output logic [7:0]                  rd_data,
  output logic                        rx_valid,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  output logic                        frame_err,
  output logic                        parity_err,
  input  logic                        clr_err
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int HALF_INT = CLK_DIV / 2;
  localparam int FULL_INT = CLK_DIV - 1;
  localparam logic [15:0] HALF_RELOAD = HALF_INT[15:0];
  localparam logic [15:0] FULL_RELOAD = FULL_INT[15:0];
  localparam logic [AW:0] DEPTH_CNT   = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_ZERO    = {(AW+1){1'b0}};

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_PAR   = 3'd4
  } state_e;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_e;
`endif

  logic        sync1_q, sync2_q, rx_s;
  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        expired_s, push_req_s, frame_set_s;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d, par_set_s, parity_err_q;
`endif

  // 2-FF synchronizer; stages reset to idle-high
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_rx;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s      = sync2_q;
  assign expired_s = (timer_q == 16'd0);

  // receiver state register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_IDLE;
      timer_q   <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // receiver next-state and frame verdict
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_req_s  = 1'b0;
    frame_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_set_s   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_s == 1'b0) begin
          state_d = S_START;
          timer_d = HALF_RELOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (expired_s) begin
          timer_d   = FULL_RELOAD;
          bit_idx_d = 3'd0;
          // a line already back high at mid-start is a glitch, not a frame
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DATA: begin
        if (expired_s) begin
          shift_d[bit_idx_q] = rx_s;
          timer_d            = FULL_RELOAD;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (expired_s) begin
          par_bad_d = (rx_s != even_parity(shift_q));
          timer_d   = FULL_RELOAD;
          state_d   = S_STOP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (expired_s) begin
          state_d = S_IDLE;
          if (!rx_s) begin
            frame_set_s = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            par_set_s = 1'b1;
`endif
          end else begin
            push_req_s = 1'b1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count_d, count_q;
  logic        empty_s, full_s, pop_s, do_push_s, ovr_set_s;
  logic        rx_valid_q, fifo_full_q, overrun_q, frame_err_q;
  logic [7:0]  rd_data_q, head_d;
  logic [7:0]  mem_q [FIFO_DEPTH];

  assign empty_s = (wptr_q == rptr_q);
  assign full_s  = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});

  // FIFO pointer update and next registered head
  always_comb begin
    pop_s     = rd_en && !empty_s;
    do_push_s = push_req_s && (!full_s || pop_s);
    ovr_set_s = push_req_s && full_s && !pop_s;
    if (do_push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    count_d = wptr_d - rptr_d;
    // the new head may be the byte being written in this very cycle
    if (count_d == PTR_ZERO) begin
      head_d = rd_data_q;
    end else if (do_push_s && (rptr_d == wptr_q)) begin
      head_d = shift_q;
    end else begin
      head_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  // FIFO storage, pointers and registered status outputs
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wptr_q      <= PTR_ZERO;
      rptr_q      <= PTR_ZERO;
      count_q     <= PTR_ZERO;
      rx_valid_q  <= 1'b0;
      fifo_full_q <= 1'b0;
      rd_data_q   <= 8'h00;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rx_valid_q  <= (count_d != PTR_ZERO);
      fifo_full_q <= (count_d == DEPTH_CNT);
      rd_data_q   <= head_d;
      if (do_push_s) begin
        mem_q[wptr_q[AW-1:0]] <= shift_q;
      end
    end
  end

  // sticky error flags; a set beats a simultaneous clear
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (ovr_set_s) begin
        overrun_q <= 1'b1;
      end else if (clr_err) begin
        overrun_q <= 1'b0;
      end
      if (frame_set_s) begin
        frame_err_q <= 1'b1;
      end else if (clr_err) begin
        frame_err_q <= 1'b0;
      end
`ifdef UART_RX_PARITY_EN
      if (par_set_s) begin
        parity_err_q <= 1'b1;
      end else if (clr_err) begin
        parity_err_q <= 1'b0;
      end
`endif
    end
  end

  assign rd_data    = rd_data_q;
  assign rx_valid   = rx_valid_q;
  assign fifo_full  = fifo_full_q;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based model
// of the received byte stream and sticky flags (CLK_DIV=16, FIFO_DEPTH=8).
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 8;
`ifdef UART_RX_PARITY_EN
  localparam logic HAS_PAR = 1'b1;
`else
  localparam logic HAS_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       serial_rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid, fifo_full, overrun, frame_err, parity_err;
  logic [3:0] fifo_count;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] model_q[$];
  logic       m_overrun = 1'b0;
  logic       m_frame = 1'b0;
  logic       m_parity = 1'b0;
  string      hello = "Hello, world! 123 ";

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .resetb(resetb), .serial_rx(serial_rx), .rd_en(rd_en),
    .rd_data(rd_data), .rx_valid(rx_valid), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .overrun(overrun), .frame_err(frame_err),
    .parity_err(parity_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ":count"},  32'(fifo_count), 32'(model_q.size()));
    check_eq({tag, ":valid"},  32'(rx_valid),   32'(model_q.size() != 0));
    check_eq({tag, ":full"},   32'(fifo_full),  32'(model_q.size() == FIFO_DEPTH));
    check_eq({tag, ":overrun"}, 32'(overrun),   32'(m_overrun));
    check_eq({tag, ":frame"},  32'(frame_err),  32'(m_frame));
    check_eq({tag, ":parity"}, 32'(parity_err), 32'(m_parity));
    if (model_q.size() > 0) check_eq({tag, ":head"}, 32'(rd_data), 32'(model_q[0]));
  endtask

  // Frame outcome by the line rules: stop low -> frame error, bad parity -> parity
  // error, otherwise stored unless full (a same-cycle pop frees a slot first).
  function automatic void model_frame(input logic [7:0] d, input logic stop_bit,
                                      input logic par_on, input logic par_bit, input logic popped);
    if (popped && model_q.size() > 0) void'(model_q.pop_front());
    if (!stop_bit) m_frame = 1'b1;
    else if (par_on && (par_bit != ^d)) m_parity = 1'b1;
    else if (model_q.size() < FIFO_DEPTH) model_q.push_back(d);
    else m_overrun = 1'b1;
  endfunction

  // Called at a negedge; drives start, 8 data bits, optional extra bit, stop.
  task automatic send_frame(input logic [7:0] d, input logic use_extra, input logic extra_bit,
                            input logic stop_bit, input logic pop_at_stop);
    serial_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_rx = d[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    if (use_extra) begin
      serial_rx = extra_bit;
      repeat (CLK_DIV) @(negedge clk);
    end
    serial_rx = stop_bit;
    if (pop_at_stop) begin
      repeat (CLK_DIV - 5) @(negedge clk);
      if (model_q.size() > 0) check_eq("pop_stop_head", 32'(rd_data), 32'(model_q[0]));
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      repeat (CLK_DIV) @(negedge clk);
    end
    serial_rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, HAS_PAR, ^d, 1'b1, 1'b0);
    model_frame(d, 1'b1, HAS_PAR, ^d, 1'b0);
  endtask

  task automatic pop_one(input string tag);
    if (model_q.size() > 0) check_eq({tag, ":pre"}, 32'(rd_data), 32'(model_q[0]));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    check_state(tag);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_overrun = 1'b0;
    m_frame = 1'b0;
    m_parity = 1'b0;
    check_state("clr");
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ":rd_data"}, 32'(rd_data), 32'h0);
    check_eq({tag, ":valid"}, 32'(rx_valid), 32'h0);
    check_eq({tag, ":full"}, 32'(fifo_full), 32'h0);
    check_eq({tag, ":count"}, 32'(fifo_count), 32'h0);
    check_eq({tag, ":flags"}, 32'({overrun, frame_err, parity_err}), 32'h0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] last_d;
    int         kind;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    resetb = 1'b1;
    repeat (4) @(negedge clk);

    // two bytes, then drain
    send_good(8'h48);
    check_state("b48");
    send_good(8'h0A);
    check_state("b0a");
    check_eq("two_count", 32'(fifo_count), 32'd2);
    pop_one("pop1");
    check_eq("pop1_head", 32'(rd_data), 32'h0A);
    pop_one("pop2");
    pop_one("pop_empty");

    // back-to-back string, never popped: first 8 kept, rest overrun
    for (int i = 0; i < hello.len(); i++) send_good(hello[i]);
    check_state("hello");
    check_eq("hello_overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      check_eq("hello_char", 32'(rd_data), 32'(hello[i]));
      pop_one("hello_pop");
    end
    pulse_clr();

    // stop bit low
    send_frame(8'h55, HAS_PAR, ^(8'h55), 1'b0, 1'b0);
    model_frame(8'h55, 1'b0, HAS_PAR, ^(8'h55), 1'b0);
    repeat (2 * CLK_DIV) @(negedge clk);
    check_state("frame_err");
    check_eq("frame_err_set", 32'(frame_err), 32'd1);
    pulse_clr();

    // short low glitch, then a real byte
    serial_rx = 1'b0;
    repeat (CLK_DIV / 4) @(negedge clk);
    serial_rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    check_state("glitch");
    send_good(8'hA5);
    check_state("after_glitch");
    pop_one("pop_a5");

    // full FIFO, byte completes in the same cycle as a pop
    for (int i = 0; i < FIFO_DEPTH; i++) send_good(8'($urandom));
    check_state("filled");
    last_d = 8'($urandom);
    send_frame(last_d, HAS_PAR, ^last_d, 1'b1, 1'b1);
    model_frame(last_d, 1'b1, HAS_PAR, ^last_d, 1'b1);
    check_state("samecyc");
    check_eq("samecyc_count", 32'(fifo_count), 32'd8);
    check_eq("samecyc_overrun", 32'(overrun), 32'd0);
    while (model_q.size() > 1) pop_one("samecyc_pop");
    check_eq("samecyc_last", 32'(rd_data), 32'(last_d));
    pop_one("samecyc_pop_last");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    model_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    check_state("par_bad");
    check_eq("par_bad_flag", 32'(parity_err), 32'd1);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    model_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    check_state("par_good");
    pop_one("par_pop");
    pulse_clr();
`else
    // an extra bit before the stop bit is taken as the stop bit
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2 * CLK_DIV) @(negedge clk);
    check_state("extra_low");
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0);
    model_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("extra_high");
    pop_one("extra_pop");
    pulse_clr();
`endif

    // randomized frames with occasional stop/parity faults and random pops
    for (int it = 0; it < 30; it++) begin
      d = 8'($urandom);
      kind = int'($urandom_range(0, 7));
      send_frame(d, HAS_PAR, (^d) ^ (kind == 1), kind != 0, 1'b0);
      model_frame(d, kind != 0, HAS_PAR, (^d) ^ (kind == 1), 1'b0);
      repeat (2 * CLK_DIV) @(negedge clk);
      check_state("rand");
      for (int p = int'($urandom_range(0, 2)); p > 0; p--) pop_one("rand_pop");
      if (kind == 7) pulse_clr();
    end

    // reset in the middle of a frame with data held
    send_good(8'h11);
    send_good(8'h22);
    serial_rx = 1'b0;
    repeat (5 * CLK_DIV) @(negedge clk);
    resetb = 1'b0;
    repeat (2) @(negedge clk);
    model_q.delete();
    m_overrun = 1'b0;
    m_frame = 1'b0;
    m_parity = 1'b0;
    check_reset_values("midreset");
    serial_rx = 1'b1;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    repeat (4) @(negedge clk);
    check_state("post_reset");
    send_good(8'h5A);
    check_state("post_reset_byte");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial UART receiver for the yrv_m1 subsystem: it deserializes 8N1 frames arriving on the serial input pin into a small first-word-fall-through FIFO that the core's I/O port reads. It is the receive counterpart of the core's serial transmit path. The testbench drives the same line format back into it, which lets the bench send command strings to firmware in addition to checking its output.

## Interface
- CLK_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range 8..65535.
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..64.
- clk  in  1  system clock; all logic on rising edge.
- resetb  in  1  asynchronous active-low reset.
- serial_rx  in  1  asynchronous serial line, idle high.
- rd_en  in  1  pop head entry; ignored when rx_valid=0.
- rd_data  out  8  FIFO head byte; valid while rx_valid=1; 8'h00 after reset.
- rx_valid  out  1  FIFO not empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- overrun  out  1  sticky: a good byte arrived while the FIFO was full.
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch (see Configuration).
- clr_err  in  1  clears all sticky flags.

## Operation
- serial_rx passes through a 2-FF synchronizer whose stages reset to 1. All decoding uses the synchronized value rx_s.
- Bit timer: a 16-bit down-counter reloaded per bit. Half-bit reload is CLK_DIV/2 (floor); full-bit reload is CLK_DIV-1.
- FSM states and transitions:
  - IDLE: on rx_s==0, load the half-bit count and go to START.
  - START: at timer expiry, sample rx_s. If 1, this is a glitch: return to IDLE and flag nothing. If 0, go to DATA with bit index 0.
  - DATA: at each expiry, shift rx_s into bit[index], LSB first. After bit 7, go to PAR if enabled, else STOP.
  - PAR: at expiry, compare rx_s against the XOR of the data bits (even parity), then go to STOP.
  - STOP: at expiry, sample rx_s.
    - 1 with no parity error: push the byte.
    - 0: set frame_err, discard the byte.
    - 1 with a parity error: set parity_err, discard the byte.
    - In every case return to IDLE immediately. The next start edge is accepted from the following cycle, so no wait for the end of the stop bit is needed.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - full = pointers equal except the MSB; empty = pointers equal.
  - Pointer wrap-around is natural modulo 2·FIFO_DEPTH.
- Push while full with no pop in the same cycle: byte dropped, overrun set, FIFO unchanged.
- Push and pop in the same cycle:
  - Both take effect and fifo_count is unchanged.
  - This also holds when full: the pop frees a slot, so there is no overrun.
- Pop while empty: no effect.
- Sticky flags: clr_err clears them. If a set and a clear fall in the same cycle, the set wins.
- Reset mid-frame: everything returns to its reset state (IDLE, FIFO empty, flags 0). If the line is low when reset releases, that is treated as a start edge.
- Reset values: rd_data=8'h00, rx_valid=0, fifo_full=0, fifo_count=0, overrun=0, frame_err=0, parity_err=0.

## Timing
- Synchronizer latency: 2 cycles from a serial_rx edge to rx_s.
- Start bit is sampled CLK_DIV/2+1 cycles after rx_s falls. Each later sample follows the previous one by CLK_DIV cycles.
- Push happens on the STOP sample cycle. rx_valid, rd_data and fifo_count update on the next rising edge.
  - Total from the start-bit falling edge on the pin: about 2 + CLK_DIV/2 + 9·CLK_DIV cycles, or 10·CLK_DIV with parity.
- rd_en pops on its clock edge. The new head appears on rd_data in the same edge's output (registered, FWFT, zero-wait).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- UART_RX_PARITY_EN defined:
  - The frame is 8E1 and the PAR state is present.
  - parity_err is active.
  - A failing frame is discarded.
- Undefined:
  - The frame is 8N1 and the PAR state is absent.
  - parity_err is tied 0.
  - A frame with an extra bit before the stop bit gets that bit treated as the stop bit.

## Test plan
- CLK_DIV=16. Send 0x48 then 0x0A -> rx_valid rises; pops return 0x48 then 0x0A; fifo_count goes 2->1->0; no flags set.
- Send the bytes of "Hello, world! 123 " back-to-back (one stop bit each) and never pop. FIFO_DEPTH=8 -> first 8 bytes held, fifo_full=1, overrun=1; pops return "Hello, w".
- Send 0x55 with the stop bit forced low -> frame_err=1 and FIFO empty. Pulse clr_err -> frame_err=0.
- Low glitch of CLK_DIV/4 cycles on the line -> no byte, no flags, FSM back in IDLE. A following 0xA5 is received correctly.
- FIFO full with a byte completing in the same cycle as rd_en -> count stays 8, overrun=0, new byte is last in order.
- With UART_RX_PARITY_EN: 0x03 with parity bit 1 -> parity_err=1, byte discarded. 0x03 with parity bit 0 -> accepted. Assert resetb mid-frame -> all outputs return to reset values.
